// File: rtl/serial_redir_pkg.sv
// Shared constants and helpers for the serial redirection FIFO block.
package serial_redir_pkg;

  localparam int unsigned SERIAL_BYTE_W     = 8;
  localparam int unsigned RX_DEPTH_BITS_DEF = 4;
  localparam int unsigned TX_DEPTH_BITS_DEF = 4;
  localparam int unsigned SYNC_LEN          = 3;

  typedef logic [SERIAL_BYTE_W-1:0] serial_byte_t;
  typedef logic [SYNC_LEN-1:0]      sync_chain_t;

  // Chain bit 0 is s1, bit 1 is s2, bit 2 is s3; a rise is s2 & ~s3.
  function automatic logic sync_rise(sync_chain_t chain);
    return chain[1] & ~chain[2];
  endfunction

endpackage

// File: rtl/serial_redir_fifo_if.sv
// SPI-side and MFP-side signal bundle of serial_redir_fifo.
interface serial_redir_fifo_if;
  import serial_redir_pkg::*;

  logic         serial_strobe_in;
  serial_byte_t serial_data_in;
  logic         serial_strobe_out;
  logic         serial_data_out_available;
  serial_byte_t serial_data_out;
  logic         rx_valid;
  serial_byte_t rx_data;
  logic         rx_ready;
  logic         tx_valid;
  serial_byte_t tx_data;
  logic         tx_ready;
  logic         rx_overrun;
  logic         rx_overrun_clr;

  modport slave (
    input  serial_strobe_in, serial_data_in, serial_strobe_out,
    input  rx_ready, tx_valid, tx_data, rx_overrun_clr,
    output serial_data_out_available, serial_data_out,
    output rx_valid, rx_data, tx_ready, rx_overrun
  );

  modport master (
    output serial_strobe_in, serial_data_in, serial_strobe_out,
    output rx_ready, tx_valid, tx_data, rx_overrun_clr,
    input  serial_data_out_available, serial_data_out,
    input  rx_valid, rx_data, tx_ready, rx_overrun
  );

endinterface

// File: rtl/redir_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a registered head output.
module redir_sync_fifo #(
  parameter int unsigned W          = 8,
  parameter int unsigned DEPTH_BITS = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int unsigned          Depth  = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] PtrOne = 1;

  logic [DEPTH_BITS:0] wptr_q, wptr_d;
  logic [DEPTH_BITS:0] rptr_q, rptr_d;
  logic [DEPTH_BITS:0] rptr_inc;
  logic [W-1:0]        mem_q [Depth];
  logic [W-1:0]        head_q, head_d;
  logic                full, empty, push_ok, pop_ok;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[DEPTH_BITS] != rptr_q[DEPTH_BITS]) &&
                    (wptr_q[DEPTH_BITS-1:0] == rptr_q[DEPTH_BITS-1:0]);
  assign pop_ok   = pop_i & ~empty;
  assign push_ok  = push_i & (~full | pop_ok);
  assign rptr_inc = rptr_q + PtrOne;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    head_d = head_q;
    if (push_ok) wptr_d = wptr_q + PtrOne;
    if (pop_ok)  rptr_d = rptr_inc;
    // Head only moves on a pop or on the first push into an empty FIFO.
    if (pop_ok) begin
      if (rptr_inc == wptr_q) begin
        if (push_ok) head_d = wdata_i;
      end else begin
        head_d = mem_q[rptr_inc[DEPTH_BITS-1:0]];
      end
    end else if (push_ok && empty) begin
      head_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      head_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[DEPTH_BITS-1:0]] <= wdata_i;
  end

  assign full_o  = full;
  assign empty_o = empty;
  assign head_o  = head_q;

endmodule

// File: rtl/serial_redir_fifo.sv
// Serial redirection buffer between SPI user I/O and the MFP USART.
// Define SERIAL_REDIR_STATS_EN to add rx_drop_cnt / tx_byte_cnt statistics outputs.
module serial_redir_fifo
  import serial_redir_pkg::*;
#(
  parameter int unsigned RX_DEPTH_BITS = RX_DEPTH_BITS_DEF,
  parameter int unsigned TX_DEPTH_BITS = TX_DEPTH_BITS_DEF
) (
  input  logic                clk_sys,
  input  logic                reset,
  serial_redir_fifo_if.slave  redir_io
`ifdef SERIAL_REDIR_STATS_EN
  ,
  output logic [7:0]          rx_drop_cnt,
  output logic [15:0]         tx_byte_cnt
`endif
);

  sync_chain_t  rx_sync_q, tx_sync_q;
  logic         rx_edge, tx_edge;
  logic         rx_full, rx_empty, tx_full, tx_empty;
  logic         rx_pop, rx_drop, tx_push;
  logic         overrun_q, overrun_d;
  serial_byte_t rx_head, tx_head;

  // Sync flops reset high so a strobe already high at reset release is not an edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rx_sync_q <= '1;
      tx_sync_q <= '1;
    end else begin
      rx_sync_q <= {rx_sync_q[SYNC_LEN-2:0], redir_io.serial_strobe_in};
      tx_sync_q <= {tx_sync_q[SYNC_LEN-2:0], redir_io.serial_strobe_out};
    end
  end

  assign rx_edge = sync_rise(rx_sync_q);
  assign tx_edge = sync_rise(tx_sync_q);
  assign rx_pop  = redir_io.rx_ready & ~rx_empty;
  assign rx_drop = rx_edge & rx_full & ~rx_pop;
  assign tx_push = redir_io.tx_valid & ~tx_full;

  redir_sync_fifo #(
    .W          (SERIAL_BYTE_W),
    .DEPTH_BITS (RX_DEPTH_BITS)
  ) u_rx_fifo (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .push_i  (rx_edge),
    .pop_i   (redir_io.rx_ready),
    .wdata_i (redir_io.serial_data_in),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .head_o  (rx_head)
  );

  redir_sync_fifo #(
    .W          (SERIAL_BYTE_W),
    .DEPTH_BITS (TX_DEPTH_BITS)
  ) u_tx_fifo (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .push_i  (tx_push),
    .pop_i   (tx_edge),
    .wdata_i (redir_io.tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .head_o  (tx_head)
  );

  always_comb begin
    overrun_d = overrun_q;
    if (redir_io.rx_overrun_clr) overrun_d = 1'b0;
    else if (rx_drop)            overrun_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end

  assign redir_io.rx_valid                  = ~rx_empty;
  assign redir_io.rx_data                   = rx_head;
  assign redir_io.tx_ready                  = ~tx_full;
  assign redir_io.serial_data_out_available = ~tx_empty;
  assign redir_io.serial_data_out           = tx_head;
  assign redir_io.rx_overrun                = overrun_q;

`ifdef SERIAL_REDIR_STATS_EN
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    if (rx_drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    if (tx_edge && !tx_empty)             tx_cnt_d   = tx_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      drop_cnt_q <= '0;
      tx_cnt_q   <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  assign rx_drop_cnt = drop_cnt_q;
  assign tx_byte_cnt = tx_cnt_q;
`endif

endmodule

// File: tb/tb_serial_redir_fifo.sv
// Directed self-checking bench for serial_redir_fifo.
module tb_serial_redir_fifo;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  serial_redir_fifo_if bus ();

`ifdef SERIAL_REDIR_STATS_EN
  logic [7:0]  rx_drop_cnt;
  logic [15:0] tx_byte_cnt;
`endif

  serial_redir_fifo #(
    .RX_DEPTH_BITS (4),
    .TX_DEPTH_BITS (4)
  ) dut (
    .clk_sys     (clk),
    .reset       (rst),
    .redir_io    (bus)
`ifdef SERIAL_REDIR_STATS_EN
    ,
    .rx_drop_cnt (rx_drop_cnt),
    .tx_byte_cnt (tx_byte_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full strobe: rise, hold until the push edge, then settle low.
  task automatic send_rx(input logic [7:0] b);
    bus.serial_data_in   = b;
    bus.serial_strobe_in = 1'b1;
    tick(3);
    bus.serial_strobe_in = 1'b0;
    tick(3);
  endtask

  task automatic pop_tx();
    bus.serial_strobe_out = 1'b1;
    tick(3);
    bus.serial_strobe_out = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    n_cmp++;
    if (bus.rx_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid);
    end
    n_cmp++;
    if (bus.serial_data_out_available !== 1'b0) begin
      n_err++; $display("FAIL reset_avail: got %b want 0", bus.serial_data_out_available);
    end
    n_cmp++;
    if (bus.tx_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_tx_ready: got %b want 1", bus.tx_ready);
    end
    n_cmp++;
    if (bus.rx_overrun !== 1'b0) begin
      n_err++; $display("FAIL reset_overrun: got %b want 0", bus.rx_overrun);
    end
    n_cmp++;
    if (bus.rx_data !== 8'h00) begin
      n_err++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data);
    end
    n_cmp++;
    if (bus.serial_data_out !== 8'h00) begin
      n_err++; $display("FAIL reset_tx_head: got %h want 00", bus.serial_data_out);
    end
    tick(3);
  endtask

  task automatic test_rx_latency();
    bus.serial_data_in   = 8'h41;
    bus.serial_strobe_in = 1'b1;
    tick(2);
    n_cmp++;
    if (bus.rx_valid !== 1'b0) begin
      n_err++; $display("FAIL rx_early: got %b want 0 after 2 edges", bus.rx_valid);
    end
    tick(1);
    n_cmp++;
    if (bus.rx_valid !== 1'b1) begin
      n_err++; $display("FAIL rx_latency: got %b want 1 after 3 edges", bus.rx_valid);
    end
    n_cmp++;
    if (bus.rx_data !== 8'h41) begin
      n_err++; $display("FAIL rx_data_41: got %h want 41", bus.rx_data);
    end
    bus.serial_strobe_in = 1'b0;
    bus.rx_ready         = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    n_cmp++;
    if (bus.rx_valid !== 1'b0) begin
      n_err++; $display("FAIL rx_pop: got %b want 0", bus.rx_valid);
    end
    tick(3);
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 17; i++) send_rx(8'(i));
    n_cmp++;
    if (bus.rx_overrun !== 1'b1) begin
      n_err++; $display("FAIL overrun_set: got %b want 1", bus.rx_overrun);
    end
`ifdef SERIAL_REDIR_STATS_EN
    n_cmp++;
    if (rx_drop_cnt !== 8'd1) begin
      n_err++; $display("FAIL drop_cnt_1: got %0d want 1", rx_drop_cnt);
    end
`endif
    // Clear held across another drop: clear wins.
    bus.rx_overrun_clr = 1'b1;
    send_rx(8'h11);
    bus.rx_overrun_clr = 1'b0;
    n_cmp++;
    if (bus.rx_overrun !== 1'b0) begin
      n_err++; $display("FAIL overrun_clr_prio: got %b want 0", bus.rx_overrun);
    end
`ifdef SERIAL_REDIR_STATS_EN
    n_cmp++;
    if (rx_drop_cnt !== 8'd2) begin
      n_err++; $display("FAIL drop_cnt_2: got %0d want 2", rx_drop_cnt);
    end
`endif
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (bus.rx_data !== 8'(i)) begin
        n_err++; $display("FAIL overrun_drain[%0d]: got %h want %h", i, bus.rx_data, 8'(i));
      end
      tick(1);
    end
    bus.rx_ready = 1'b0;
    n_cmp++;
    if (bus.rx_valid !== 1'b0) begin
      n_err++; $display("FAIL overrun_lost: got rx_valid %b want 0", bus.rx_valid);
    end
  endtask

  task automatic test_tx();
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hA5;
    tick(1);
    n_cmp++;
    if (bus.serial_data_out_available !== 1'b1) begin
      n_err++; $display("FAIL tx_avail: got %b want 1", bus.serial_data_out_available);
    end
    bus.tx_data = 8'h5A;
    tick(1);
    bus.tx_valid = 1'b0;
    n_cmp++;
    if (bus.serial_data_out !== 8'hA5) begin
      n_err++; $display("FAIL tx_head_a5: got %h want a5", bus.serial_data_out);
    end
    pop_tx();
    n_cmp++;
    if (bus.serial_data_out !== 8'h5A) begin
      n_err++; $display("FAIL tx_head_5a: got %h want 5a", bus.serial_data_out);
    end
    n_cmp++;
    if (bus.serial_data_out_available !== 1'b1) begin
      n_err++; $display("FAIL tx_avail_mid: got %b want 1", bus.serial_data_out_available);
    end
    pop_tx();
    n_cmp++;
    if (bus.serial_data_out_available !== 1'b0) begin
      n_err++; $display("FAIL tx_drained: got %b want 0", bus.serial_data_out_available);
    end
`ifdef SERIAL_REDIR_STATS_EN
    n_cmp++;
    if (tx_byte_cnt !== 16'd2) begin
      n_err++; $display("FAIL tx_cnt_2: got %0d want 2", tx_byte_cnt);
    end
`endif
  endtask

  task automatic test_tx_empty_pop();
    pop_tx();
    n_cmp++;
    if (bus.serial_data_out_available !== 1'b0) begin
      n_err++; $display("FAIL empty_pop_avail: got %b want 0", bus.serial_data_out_available);
    end
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h33;
    tick(1);
    bus.tx_valid = 1'b0;
    n_cmp++;
    if (bus.serial_data_out !== 8'h33) begin
      n_err++; $display("FAIL empty_pop_head: got %h want 33", bus.serial_data_out);
    end
    pop_tx();
    n_cmp++;
    if (bus.serial_data_out_available !== 1'b0) begin
      n_err++; $display("FAIL empty_pop_one: got %b want 0", bus.serial_data_out_available);
    end
`ifdef SERIAL_REDIR_STATS_EN
    n_cmp++;
    if (tx_byte_cnt !== 16'd3) begin
      n_err++; $display("FAIL tx_cnt_3: got %0d want 3", tx_byte_cnt);
    end
`endif
  endtask

  task automatic test_full_pop_same_cycle();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) send_rx(8'h20 + 8'(i));
    bus.serial_data_in   = 8'h77;
    bus.serial_strobe_in = 1'b1;
    tick(2);
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready         = 1'b0;
    bus.serial_strobe_in = 1'b0;
    tick(3);
    n_cmp++;
    if (bus.rx_overrun !== 1'b0) begin
      n_err++; $display("FAIL full_pop_overrun: got %b want 0", bus.rx_overrun);
    end
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 8'h21 + 8'(i) : 8'h77;
      n_cmp++;
      if (bus.rx_data !== exp) begin
        n_err++; $display("FAIL full_pop_drain[%0d]: got %h want %h", i, bus.rx_data, exp);
      end
      tick(1);
    end
    bus.rx_ready = 1'b0;
    n_cmp++;
    if (bus.rx_valid !== 1'b0) begin
      n_err++; $display("FAIL full_pop_count: got rx_valid %b want 0", bus.rx_valid);
    end
  endtask

  task automatic test_strobe_through_reset();
    send_rx(8'h99);
    bus.serial_strobe_in = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(6);
    n_cmp++;
    if (bus.rx_valid !== 1'b0) begin
      n_err++; $display("FAIL held_strobe: got rx_valid %b want 0", bus.rx_valid);
    end
`ifdef SERIAL_REDIR_STATS_EN
    n_cmp++;
    if (rx_drop_cnt !== 8'd0 || tx_byte_cnt !== 16'd0) begin
      n_err++; $display("FAIL stats_reset: got %0d/%0d want 0/0", rx_drop_cnt, tx_byte_cnt);
    end
`endif
    bus.serial_strobe_in = 1'b0;
    tick(3);
    send_rx(8'h5C);
    n_cmp++;
    if (bus.rx_data !== 8'h5C) begin
      n_err++; $display("FAIL post_reset_rx: got %h want 5c", bus.rx_data);
    end
  endtask

  initial begin
    n_cmp                 = 0;
    n_err                 = 0;
    rst                   = 1'b1;
    bus.serial_strobe_in  = 1'b0;
    bus.serial_data_in    = 8'h00;
    bus.serial_strobe_out = 1'b0;
    bus.rx_ready          = 1'b0;
    bus.tx_valid          = 1'b0;
    bus.tx_data           = 8'h00;
    bus.rx_overrun_clr    = 1'b0;
    test_reset();
    test_rx_latency();
    test_overrun();
    test_tx();
    test_tx_empty_pop();
    test_full_pop_same_cycle();
    test_strobe_through_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
